// File: rtl/cache_port_arbiter.sv
// Two-requester (IFU / LSU) arbiter for the single CPU-side port of the data cache controller.
// Optional macro CACHE_ARB_LSU_PRIO_EN: LSU always wins a tie instead of round-robin.
module cache_port_arbiter #(
    parameter int unsigned ADDR_LEN       = 27,
    parameter int unsigned DATA_LEN       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_LEN        = 13
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ifu_req,
    input  logic [ADDR_LEN-1:0] ifu_addr,
    output logic                ifu_ack,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    output logic                lsu_ack,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                cache_req,
    output logic                cache_rw,
    output logic [ADDR_LEN-1:0] cache_addr,
    output logic [DATA_LEN-1:0] cache_wdata,
    input  logic [DATA_LEN-1:0] cache_rdata,
    input  logic                cache_done,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_e;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;
    localparam logic [CNT_LEN-1:0] TIMEOUT_CNT = CNT_LEN'(TIMEOUT_CYCLES);

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_grant_q, last_grant_d;
    logic                cache_req_q, cache_req_d;
    logic                cache_rw_q, cache_rw_d;
    logic [ADDR_LEN-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_LEN-1:0] cache_wdata_q, cache_wdata_d;
    logic                ifu_ack_q, ifu_ack_d;
    logic                lsu_ack_q, lsu_ack_d;
    logic [DATA_LEN-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_LEN-1:0] lsu_rdata_q, lsu_rdata_d;
    logic [CNT_LEN-1:0]  wd_cnt_q, wd_cnt_d;
    logic                err_q, err_d;
    logic                pick_lsu;

`ifdef CACHE_ARB_LSU_PRIO_EN
    assign pick_lsu = lsu_req;
`else
    // On a tie the requester that was not served last time wins.
    assign pick_lsu = lsu_req && (!ifu_req || (last_grant_q == GNT_IFU));
`endif

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_grant_d  = last_grant_q;
        cache_req_d   = cache_req_q;
        cache_rw_d    = cache_rw_q;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        ifu_ack_d     = 1'b0;
        lsu_ack_d     = 1'b0;
        ifu_rdata_d   = ifu_rdata_q;
        lsu_rdata_d   = lsu_rdata_q;
        wd_cnt_d      = wd_cnt_q;
        err_d         = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ifu_req || lsu_req) begin
                    gnt_d         = pick_lsu;
                    last_grant_d  = pick_lsu;
                    cache_addr_d  = pick_lsu ? lsu_addr : ifu_addr;
                    cache_wdata_d = pick_lsu ? lsu_wdata : '0;
                    cache_rw_d    = pick_lsu ? ~lsu_we : 1'b1;
                    cache_req_d   = 1'b1;
                    wd_cnt_d      = '0;
                    state_d       = S_BUSY;
                end
            end
            S_BUSY: begin
                wd_cnt_d = (wd_cnt_q == TIMEOUT_CNT) ? wd_cnt_q : wd_cnt_q + CNT_LEN'(1);
                if (wd_cnt_d == TIMEOUT_CNT) begin
                    err_d = 1'b1;
                end
                if (cache_done) begin
                    if (gnt_q == GNT_IFU) begin
                        ifu_rdata_d = cache_rdata;
                        ifu_ack_d   = 1'b1;
                    end else begin
                        if (cache_rw_q) begin
                            lsu_rdata_d = cache_rdata;
                        end
                        lsu_ack_d = 1'b1;
                    end
                    cache_req_d = 1'b0;
                    state_d     = S_ACK;
                end
            end
            S_ACK: begin
                // Idle cycle with cache_req low lets the cache controller clear its finish flag.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            gnt_q         <= GNT_IFU;
            last_grant_q  <= GNT_IFU;
            cache_req_q   <= 1'b0;
            cache_rw_q    <= 1'b1;
            cache_addr_q  <= '0;
            cache_wdata_q <= '0;
            ifu_ack_q     <= 1'b0;
            lsu_ack_q     <= 1'b0;
            ifu_rdata_q   <= '0;
            lsu_rdata_q   <= '0;
            wd_cnt_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_grant_q  <= last_grant_d;
            cache_req_q   <= cache_req_d;
            cache_rw_q    <= cache_rw_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            ifu_ack_q     <= ifu_ack_d;
            lsu_ack_q     <= lsu_ack_d;
            ifu_rdata_q   <= ifu_rdata_d;
            lsu_rdata_q   <= lsu_rdata_d;
            wd_cnt_q      <= wd_cnt_d;
            err_q         <= err_d;
        end
    end

    assign ifu_ack     = ifu_ack_q;
    assign ifu_rdata   = ifu_rdata_q;
    assign lsu_ack     = lsu_ack_q;
    assign lsu_rdata   = lsu_rdata_q;
    assign cache_req   = cache_req_q;
    assign cache_rw    = cache_rw_q;
    assign cache_addr  = cache_addr_q;
    assign cache_wdata = cache_wdata_q;
    assign err         = err_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: cycle-by-cycle vector table plus hand-written sequences.
module tb_cache_port_arbiter;

    localparam int AL = 27;
    localparam int DL = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ifu_req, lsu_req, lsu_we, cache_done;
    logic [AL-1:0] ifu_addr, lsu_addr;
    logic [DL-1:0] lsu_wdata, cache_rdata;
    logic          ifu_ack, lsu_ack, cache_req, cache_rw, err;
    logic [DL-1:0] ifu_rdata, lsu_rdata, cache_wdata;
    logic [AL-1:0] cache_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .ADDR_LEN      (AL),
        .DATA_LEN      (DL),
        .TIMEOUT_CYCLES(8),
        .CNT_LEN       (13)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ifu_req    (ifu_req),
        .ifu_addr   (ifu_addr),
        .ifu_ack    (ifu_ack),
        .ifu_rdata  (ifu_rdata),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_ack    (lsu_ack),
        .lsu_rdata  (lsu_rdata),
        .cache_req  (cache_req),
        .cache_rw   (cache_rw),
        .cache_addr (cache_addr),
        .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata),
        .cache_done (cache_done),
        .err        (err)
    );

    typedef struct packed {
        logic          rstn, ireq;
        logic [AL-1:0] iaddr;
        logic          lreq, lwe;
        logic [AL-1:0] laddr;
        logic [DL-1:0] lwd;
        logic          done;
        logic [DL-1:0] rdata;
        logic          e_iack, e_lack, e_creq, e_crw;
        logic [AL-1:0] e_caddr;
        logic [DL-1:0] e_irdata, e_lrdata;
    } vec_t;

    localparam int NV = 34;
    vec_t vec [NV];

    localparam logic [AL-1:0] AI = 27'h100, AW = 27'h204, AI2 = 27'h400, AL2 = 27'h500;
    localparam logic [DL-1:0] WD = 32'h12345678, D1 = 32'hDEADBEEF, DB = 32'hBAD0BAD0;
    localparam logic [DL-1:0] D2 = 32'h11111111, D3 = 32'h22222222, D4 = 32'h33333333;
    localparam logic [DL-1:0] D5 = 32'h44444444, D6 = 32'h55555555, D7 = 32'h66666666;
    localparam logic [DL-1:0] DX = 32'hFFFFFFFF;

    // Outcome of the tie in row 31, taken right after an LSU grant.
`ifdef CACHE_ARB_LSU_PRIO_EN
    localparam logic [AL-1:0] TIE_A = AL2;
    localparam logic TIE_IACK = 1'b0, TIE_LACK = 1'b1;
    localparam logic [DL-1:0] TIE_IRD = D5, TIE_LRD = D7;
`else
    localparam logic [AL-1:0] TIE_A = AI2;
    localparam logic TIE_IACK = 1'b1, TIE_LACK = 1'b0;
    localparam logic [DL-1:0] TIE_IRD = D7, TIE_LRD = D6;
`endif

    function automatic vec_t row(input logic r, input logic ir, input logic [AL-1:0] ia,
                                 input logic lr, input logic lw, input logic [AL-1:0] la,
                                 input logic [DL-1:0] lwd, input logic dn, input logic [DL-1:0] rd,
                                 input logic eia, input logic ela, input logic ecr,
                                 input logic erw, input logic [AL-1:0] eca,
                                 input logic [DL-1:0] eir, input logic [DL-1:0] elr);
        return '{r, ir, ia, lr, lw, la, lwd, dn, rd, eia, ela, ecr, erw, eca, eir, elr};
    endfunction

    task automatic fill();
        // Single IFU read, done in cycle 5, ack in cycle 6.
        vec[0]  = row(1, 1, AI, 0, 0, 0, 0, 0, 0,     0, 0, 1, 1, AI, 0, 0);
        for (int i = 1; i < 5; i++)
            vec[i] = row(1, 1, AI, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, AI, 0, 0);
        vec[5]  = row(1, 1, AI, 0, 0, 0, 0, 1, D1,    1, 0, 0, 1, AI, D1, 0);
        vec[6]  = row(1, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, AI, D1, 0);
        vec[7]  = row(1, 0, 0, 0, 0, 0, 0, 1, DX,     0, 0, 0, 1, AI, D1, 0);
        // LSU write: rw=0, lsu_rdata untouched.
        vec[8]  = row(1, 0, 0, 1, 1, AW, WD, 0, 0,    0, 0, 1, 0, AW, D1, 0);
        vec[9]  = row(1, 0, 0, 1, 1, AW, WD, 1, DB,   0, 1, 0, 0, AW, D1, 0);
        vec[10] = row(1, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, AW, D1, 0);
        vec[11] = row(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0);
        // Tie after reset: LSU first, then IFU; done 3 cycles after each cache_req.
        vec[12] = row(1, 1, AI2, 1, 0, AL2, 0, 0, 0,  0, 0, 1, 1, AL2, 0, 0);
        vec[13] = row(1, 1, AI2, 1, 0, AL2, 0, 0, 0,  0, 0, 1, 1, AL2, 0, 0);
        vec[14] = row(1, 1, AI2, 1, 0, AL2, 0, 0, 0,  0, 0, 1, 1, AL2, 0, 0);
        vec[15] = row(1, 1, AI2, 1, 0, AL2, 0, 1, D2, 0, 1, 0, 1, AL2, 0, D2);
        vec[16] = row(1, 1, AI2, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, AL2, 0, D2);
        vec[17] = row(1, 1, AI2, 0, 0, 0, 0, 0, 0,    0, 0, 1, 1, AI2, 0, D2);
        vec[18] = row(1, 1, AI2, 0, 0, 0, 0, 0, 0,    0, 0, 1, 1, AI2, 0, D2);
        vec[19] = row(1, 1, AI2, 0, 0, 0, 0, 0, 0,    0, 0, 1, 1, AI2, 0, D2);
        vec[20] = row(1, 1, AI2, 0, 0, 0, 0, 1, D3,   1, 0, 0, 1, AI2, D3, D2);
        // Repeat tie (last grant IFU): LSU again, then IFU.
        vec[21] = row(1, 1, AI2, 1, 0, AL2, 0, 0, 0,  0, 0, 0, 1, AI2, D3, D2);
        vec[22] = row(1, 1, AI2, 1, 0, AL2, 0, 0, 0,  0, 0, 1, 1, AL2, D3, D2);
        vec[23] = row(1, 1, AI2, 1, 0, AL2, 0, 1, D4, 0, 1, 0, 1, AL2, D3, D4);
        vec[24] = row(1, 1, AI2, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, AL2, D3, D4);
        vec[25] = row(1, 1, AI2, 0, 0, 0, 0, 0, 0,    0, 0, 1, 1, AI2, D3, D4);
        vec[26] = row(1, 1, AI2, 0, 0, 0, 0, 1, D5,   1, 0, 0, 1, AI2, D5, D4);
        vec[27] = row(1, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, AI2, D5, D4);
        // LSU alone, then a tie with last grant = LSU.
        vec[28] = row(1, 0, 0, 1, 0, AL2, 0, 0, 0,    0, 0, 1, 1, AL2, D5, D4);
        vec[29] = row(1, 0, 0, 1, 0, AL2, 0, 1, D6,   0, 1, 0, 1, AL2, D5, D6);
        vec[30] = row(1, 1, AI2, 1, 0, AL2, 0, 0, 0,  0, 0, 0, 1, AL2, D5, D6);
        vec[31] = row(1, 1, AI2, 1, 0, AL2, 0, 0, 0,  0, 0, 1, 1, TIE_A, D5, D6);
        vec[32] = row(1, 1, AI2, 1, 0, AL2, 0, 1, D7,
                      TIE_IACK, TIE_LACK, 0, 1, TIE_A, TIE_IRD, TIE_LRD);
        vec[33] = row(1, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, TIE_A, TIE_IRD, TIE_LRD);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req = 0; ifu_addr = '0; lsu_req = 0; lsu_we = 0; lsu_addr = '0;
        lsu_wdata = '0; cache_done = 0; cache_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        fill();
        rstn = 0;
        idle_inputs();
        repeat (3) tick();
        chk("rst cache_req", 32'(cache_req), 0);
        chk("rst cache_rw", 32'(cache_rw), 1);
        chk("rst cache_addr", 32'(cache_addr), 0);
        chk("rst cache_wdata", cache_wdata, 0);
        chk("rst acks", {30'd0, ifu_ack, lsu_ack}, 0);
        chk("rst rdata", ifu_rdata | lsu_rdata, 0);
        chk("rst err", 32'(err), 0);

        for (int i = 0; i < NV; i++) begin
            rstn = vec[i].rstn; ifu_req = vec[i].ireq; ifu_addr = vec[i].iaddr;
            lsu_req = vec[i].lreq; lsu_we = vec[i].lwe; lsu_addr = vec[i].laddr;
            lsu_wdata = vec[i].lwd; cache_done = vec[i].done; cache_rdata = vec[i].rdata;
            tick();
            chk($sformatf("row%0d ifu_ack", i), 32'(ifu_ack), 32'(vec[i].e_iack));
            chk($sformatf("row%0d lsu_ack", i), 32'(lsu_ack), 32'(vec[i].e_lack));
            chk($sformatf("row%0d cache_req", i), 32'(cache_req), 32'(vec[i].e_creq));
            chk($sformatf("row%0d cache_rw", i), 32'(cache_rw), 32'(vec[i].e_crw));
            chk($sformatf("row%0d cache_addr", i), 32'(cache_addr), 32'(vec[i].e_caddr));
            chk($sformatf("row%0d ifu_rdata", i), ifu_rdata, vec[i].e_irdata);
            chk($sformatf("row%0d lsu_rdata", i), lsu_rdata, vec[i].e_lrdata);
            chk($sformatf("row%0d err", i), 32'(err), 0);
        end
        chk("tbl wdata", cache_wdata, 0);

        // Back-to-back LSU: read, then write with new fields while req stays high.
        idle_inputs();
        lsu_req = 1; lsu_addr = 27'h250;
        tick();
        chk("b2b first req", 32'(cache_req), 1);
        chk("b2b first addr", 32'(cache_addr), 32'h250);
        lsu_addr = 27'h777;
        tick();
        chk("b2b addr stable", 32'(cache_addr), 32'h250);
        cache_done = 1; cache_rdata = 32'hA5A5A5A5;
        tick();
        cache_done = 0;
        chk("b2b ack1", 32'(lsu_ack), 1);
        chk("b2b rdata1", lsu_rdata, 32'hA5A5A5A5);
        lsu_addr = 27'h300; lsu_we = 1; lsu_wdata = 32'hCAFEF00D;
        tick();
        chk("b2b gap req", 32'(cache_req), 0);
        chk("b2b ack pulse", 32'(lsu_ack), 0);
        tick();
        chk("b2b second req", 32'(cache_req), 1);
        chk("b2b second addr", 32'(cache_addr), 32'h300);
        chk("b2b second rw", 32'(cache_rw), 0);
        chk("b2b second wdata", cache_wdata, 32'hCAFEF00D);
        lsu_req = 0; cache_done = 1; cache_rdata = 32'h0BADF00D;
        tick();
        cache_done = 0;
        chk("b2b ack2", 32'(lsu_ack), 1);
        chk("b2b write keeps rdata", lsu_rdata, 32'hA5A5A5A5);
        tick();
        chk("b2b ack2 off", 32'(lsu_ack), 0);

        // Watchdog: done withheld well past 8 busy cycles.
        ifu_req = 1; ifu_addr = 27'h640;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 6) chk("wd err early", 32'(err), 0);
            if (k == 10) chk("wd err set", 32'(err), 1);
        end
        chk("wd still busy", 32'(cache_req), 1);
        chk("wd no ack", 32'(ifu_ack), 0);
        cache_done = 1; cache_rdata = 32'h5A5A0001;
        tick();
        cache_done = 0; ifu_req = 0;
        chk("wd late ack", 32'(ifu_ack), 1);
        chk("wd late rdata", ifu_rdata, 32'h5A5A0001);
        tick();
        chk("wd err sticky", 32'(err), 1);
        rstn = 0;
        tick();
        rstn = 1;
        chk("wd err cleared", 32'(err), 0);

        // Done in the same cycle the count reaches the threshold.
        ifu_req = 1; ifu_addr = 27'h660;
        repeat (8) tick();
        chk("thr busy8 req", 32'(cache_req), 1);
        cache_done = 1; cache_rdata = 32'h5A5A0002;
        tick();
        cache_done = 0; ifu_req = 0;
        chk("thr ack", 32'(ifu_ack), 1);
        chk("thr rdata", ifu_rdata, 32'h5A5A0002);
        chk("thr err", 32'(err), 1);
        rstn = 0;
        tick();
        rstn = 1;

        // Reset mid-access, then a fresh request is served normally.
        ifu_req = 1; ifu_addr = 27'h680;
        tick();
        tick();
        chk("mid busy", 32'(cache_req), 1);
        rstn = 0;
        tick();
        chk("mid rst req", 32'(cache_req), 0);
        chk("mid rst ack", {30'd0, ifu_ack, lsu_ack}, 0);
        rstn = 1; ifu_addr = 27'h6C0;
        tick();
        chk("mid new req", 32'(cache_req), 1);
        chk("mid new addr", 32'(cache_addr), 32'h6C0);
        chk("mid no stale ack", 32'(ifu_ack), 0);
        cache_done = 1; cache_rdata = 32'h5A5A0003;
        tick();
        cache_done = 0; ifu_req = 0;
        chk("mid new ack", 32'(ifu_ack), 1);
        chk("mid new rdata", ifu_rdata, 32'h5A5A0003);
        chk("mid err", 32'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
